stream_feeder: RTL

Jitter-absorbing input stage that sits directly upstream of the array-writer block and drives its `data_in` byte bus. The array writer stores one byte on every clock with no handshake. This block therefore accepts bursty valid/ready traffic into a small FIFO. It prefills the FIFO to a threshold, then emits exactly one byte per cycle, substituting a fill byte and counting underruns whenever the FIFO runs dry.

---
 rtl/stream_feeder_pkg.sv | 18 +
 rtl/feeder_fifo_ram.sv | 27 ++
 rtl/stream_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stream_feeder_pkg.sv
// Shared types and constants for the stream feeder and the array writer it drives.
package stream_feeder_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] DEFAULT_FILL_BYTE = 8'h00;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } feeder_state_t;

    // Eight-bit event counter that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/feeder_fifo_ram.sv
// DEPTH x DATA_W storage for the feeder FIFO: synchronous write, combinational read of the head.
module feeder_fifo_ram
    import stream_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The head must be visible in the same cycle the pop is decided.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_feeder.sv
// Absorbs bursty valid/ready input into a FIFO, prefills to START_LEVEL, then emits one byte per clock.
module stream_feeder
    import stream_feeder_pkg::*;
#(
    parameter int                DEPTH       = 16,
    parameter int                START_LEVEL = 4,
    parameter logic [DATA_W-1:0] FILL_BYTE   = DEFAULT_FILL_BYTE,
    localparam int               AW          = $clog2(DEPTH),
    localparam int               LW          = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fill,
    output logic [LW-1:0]     level,
    output logic [7:0]        underrun_count
);

    localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
    localparam logic [LW-1:0] START_THRES = LW'(START_LEVEL);

    feeder_state_t     state_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_fill_reg;
    logic [7:0]        underrun_reg;

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    // Readiness looks only at the registered level; a same-cycle pop does not free a slot.
    assign in_ready   = !flush && (level_reg != FULL_LEVEL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (level_reg == '0);
    assign pop        = (state_reg == ST_RUN) && !fifo_empty && !flush;

    always_comb begin
        level_next = level_reg;
        unique case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    feeder_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && !rst),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_PRIME;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            out_data_reg <= FILL_BYTE;
            out_fill_reg <= 1'b1;
            underrun_reg <= 8'd0;
        end else if (flush) begin
            // Discard buffered bytes but keep the underrun history.
            state_reg    <= ST_PRIME;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            out_data_reg <= FILL_BYTE;
            out_fill_reg <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;

            unique case (state_reg)
                ST_PRIME: begin
                    out_data_reg <= FILL_BYTE;
                    out_fill_reg <= 1'b1;
                    if (level_reg >= START_THRES) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!fifo_empty) begin
                        out_data_reg <= head;
                        out_fill_reg <= 1'b0;
                    end else begin
                        out_data_reg <= FILL_BYTE;
                        out_fill_reg <= 1'b1;
                        underrun_reg <= sat_inc8(underrun_reg);
                        state_reg    <= ST_PRIME;
                    end
                end
                default: begin
                    state_reg <= ST_PRIME;
                end
            endcase
        end
    end

    assign out_data       = out_data_reg;
    assign out_fill       = out_fill_reg;
    assign level          = level_reg;
    assign underrun_count = underrun_reg;

endmodule
